// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream (length, big-endian words, XOR checksum),
// writes the words into instruction memory, and releases the CPU reset once the frame verifies.
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [16:0]           MAX_WORDS = 17'(2 ** (ADDR_WIDTH - 2));

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t      state;
  logic [15:0] len;
  logic [23:0] wbuf;
  logic [1:0]  bcnt;
  logic [7:0]  csum;
  logic        xfer;

  assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CSUM);
  assign busy     = in_ready;
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      len          <= '0;
      wbuf         <= '0;
      bcnt         <= '0;
      csum         <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_rst_n    <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_LEN_HI;
            words_loaded <= '0;
            csum         <= '0;
            bcnt         <= '0;
            cpu_rst_n    <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= in_data;
            state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= in_data;
            if ({1'b0, len[15:8], in_data} > MAX_WORDS)
              state <= S_ERROR;
            else if ({len[15:8], in_data} == 16'd0)
              state <= S_CSUM;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            wbuf <= {wbuf[15:0], in_data};
            csum <= csum ^ in_data;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              // Word is emitted from the shift buffer plus the byte arriving now.
              mem_we       <= 1'b1;
              mem_wdata    <= {wbuf, in_data};
              mem_addr     <= BASE + {words_loaded[ADDR_WIDTH-3:0], 2'b00};
              words_loaded <= words_loaded + 16'd1;
              if ((words_loaded + 16'd1) == len)
                state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (in_data == csum) begin
              state     <= S_DONE;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= S_ERROR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table-driven frames, hand-written corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_imem_boot_loader;

  localparam int unsigned AW   = 10;
  localparam int unsigned BASE = 0;
  localparam int unsigned MAXW = 2 ** (AW - 2);

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, cpu_rst_n, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [15:0]   words_loaded;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW+31:0] wq[$];
  logic [31:0]    src_q[$];

  typedef struct {
    logic [15:0] len;
    logic [7:0]  flip;
    int          gmode;
    bit          edone;
    bit          eerr;
  } vec_t;

  vec_t vt[10];

  imem_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_we) wq.push_back({mem_addr, mem_wdata});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_gap(input int gmode);
    int g;
    g = (gmode == 1) ? 1 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      start = ($urandom % 3 == 0);
      @(negedge clk);
      start = 1'b0;
      chk("gap_in_ready", in_ready, 1);
    end
  endtask

  task automatic run_frame(input logic [15:0] len, input logic [7:0] flip, input int gmode,
                           input bit edone, input bit eerr);
    logic [31:0]    w;
    logic [7:0]     x, b;
    logic [AW+31:0] eq[$];
    int             n;
    wq.delete();
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_cpu_rst_n", cpu_rst_n, 0);
    chk("start_words", words_loaded, 0);
    send(len[15:8]);
    do_gap(gmode);
    send(len[7:0]);
    if (int'(len) > MAXW) begin
      chk("len_err_flag", error, eerr);
      chk("len_err_ready", in_ready, 0);
      chk("len_err_cpu_rst_n", cpu_rst_n, 0);
      chk("len_err_writes", wq.size(), 0);
    end else begin
      x = 8'h00;
      for (int i = 0; i < int'(len); i++) begin
        w = (src_q.size() > 0) ? src_q.pop_front() : $urandom;
        eq.push_back({AW'(BASE + 4 * i), w});
        for (int k = 0; k < 4; k++) begin
          b = w[31 - 8 * k -: 8];
          x ^= b;
          do_gap(gmode);
          send(b);
        end
      end
      do_gap(gmode);
      send(x ^ flip);
      chk("done", done, edone);
      chk("error", error, eerr);
      chk("cpu_rst_n", cpu_rst_n, edone);
      chk("words_loaded", words_loaded, len);
      chk("write_count", wq.size(), eq.size());
      n = (wq.size() < eq.size()) ? wq.size() : eq.size();
      for (int i = 0; i < n; i++) chk("write_addr_data", wq[i], eq[i]);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_mem_we"}, mem_we, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_wdata"}, mem_wdata, 0);
    chk({nm, "_cpu_rst_n"}, cpu_rst_n, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_error"}, error, 0);
    chk({nm, "_in_ready"}, in_ready, 0);
    chk({nm, "_words"}, words_loaded, 0);
  endtask

  initial begin
    logic [15:0] rl;
    logic [7:0]  rf;
    bit          ok;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Reference frame: two MIPS words
    src_q = '{32'h24100004, 32'h03E00008};
    run_frame(16'd2, 8'h00, 0, 1'b1, 1'b0);
    src_q = '{32'h24100004, 32'h03E00008};
    run_frame(16'd2, 8'h01, 0, 1'b0, 1'b1);

    vt[0] = '{16'd0,      8'h00, 0, 1'b1, 1'b0};
    vt[1] = '{16'd0,      8'h5A, 0, 1'b0, 1'b1};
    vt[2] = '{16'h0101,   8'h00, 0, 1'b0, 1'b1};
    vt[3] = '{16'd1,      8'h00, 1, 1'b1, 1'b0};
    vt[4] = '{16'd256,    8'h00, 0, 1'b1, 1'b0};
    vt[5] = '{16'hFFFF,   8'h00, 0, 1'b0, 1'b1};
    vt[6] = '{16'd3,      8'h00, 2, 1'b1, 1'b0};
    vt[7] = '{16'd4,      8'h80, 2, 1'b0, 1'b1};
    vt[8] = '{16'd1,      8'h00, 0, 1'b1, 1'b0};
    vt[9] = '{16'd257,    8'h00, 1, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++)
      run_frame(vt[i].len, vt[i].flip, vt[i].gmode, vt[i].edone, vt[i].eerr);

    // Asynchronous reset after 5 of 8 data bytes
    pulse_start();
    send(8'h00); send(8'h02);
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4); send(8'hE5);
    chk("pre_reset_words", words_loaded, 1);
    wq.delete();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (3) @(negedge clk);
    chk("reset_no_writes", wq.size(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(16'd1, 8'h00, 0, 1'b1, 1'b0);

    for (int r = 0; r < 25; r++) begin
      rl = ($urandom % 8 == 0) ? 16'(257 + $urandom % 100) : 16'($urandom % 10);
      rf = ($urandom % 4 == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      ok = (int'(rl) <= MAXW) && (rf == 8'h00);
      run_frame(rl, rf, 2, ok, !ok);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
